// File: rtl/rst_code_pkg.sv
// Shared reset-code line constants and types.
// The transmitter (sync board) and the backend receiver both import this package.
package rst_code_pkg;

    localparam int         RST_CODE_BITS   = 4;
    localparam logic [3:0] RST_CODE_IDLE   = 4'b1010;
    localparam logic [3:0] RST_CODE_ACTIVE = 4'b1100;

    // A clean run this long forgives earlier isolated error cycles.
    localparam int CLEAN_GAP = 8;

    // History holds one full frame plus the bit before it.
    localparam int HIST_W = RST_CODE_BITS + 1;

    // Both idle and active frames end in 0, so an active frame is always
    // preceded by a 0. Matching 0-1100 in the history finds the active frame
    // at any phase, and can never match inside an idle stream.
    localparam logic [HIST_W-1:0] DET_PATTERN = {1'b0, RST_CODE_ACTIVE};

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    // Legal streams never contain three equal consecutive bits.
    function automatic logic is_err_window(input logic [2:0] w);
        return (w == 3'b000) || (w == 3'b111);
    endfunction

endpackage

// File: rtl/rst_code_lock.sv
// Line-health tracker for the reset-code line.
// It hunts for a run of alternating bits to declare lock, then drops lock
// when error cycles pile up without a clean gap between them.
module rst_code_lock
    import rst_code_pkg::*;
#(
    parameter int LOCK_COUNT  = 16,
    parameter int UNLOCK_ERRS = 2
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic [HIST_W-1:0] hist,
    output logic              locked
);

    localparam int ALIGN_W = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W   = $clog2(UNLOCK_ERRS + 1);
    localparam int CLEAN_W = $clog2(CLEAN_GAP + 1);

    localparam logic [ALIGN_W-1:0] ALIGN_LAST = ALIGN_W'(LOCK_COUNT - 1);
    localparam logic [BAD_W-1:0]   BAD_LAST   = BAD_W'(UNLOCK_ERRS - 1);
    localparam logic [CLEAN_W-1:0] CLEAN_LAST = CLEAN_W'(CLEAN_GAP - 1);
    localparam logic [CLEAN_W-1:0] CLEAN_FULL = CLEAN_W'(CLEAN_GAP);

    lock_state_e        state;
    lock_state_e        state_nxt;
    logic [ALIGN_W-1:0] align_cnt;
    logic [BAD_W-1:0]   bad_cnt;
    logic [CLEAN_W-1:0] clean_cnt;
    logic               trans;
    logic               err_cyc;
    logic               unused_hist;

    assign trans   = hist[0] ^ hist[1];
    assign err_cyc = is_err_window(hist[2:0]);

    // The older history bits only matter to the frame detector in the top.
    assign unused_hist = ^hist[HIST_W-1:3];

    // State register
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: lock on the LOCK_COUNT-th consecutive transition, unlock on
    // the error cycle that brings bad_cnt up to UNLOCK_ERRS
    always_comb begin
        state_nxt = state;
        unique case (state)
            HUNT: begin
                if (trans && (align_cnt == ALIGN_LAST)) begin
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (err_cyc && (bad_cnt == BAD_LAST)) begin
                    state_nxt = HUNT;
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    // Output decode
    always_comb begin
        locked = (state == LOCKED);
    end

    // Alignment run: consecutive transitions seen while hunting
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            align_cnt <= '0;
        end else if ((state == HUNT) && (state_nxt == HUNT) && trans) begin
            align_cnt <= align_cnt + 1'b1;
        end else begin
            align_cnt <= '0;
        end
    end

    // Error bookkeeping while locked; fresh on every entry to LOCKED
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_cnt   <= '0;
            clean_cnt <= '0;
        end else if ((state != LOCKED) || (state_nxt != LOCKED)) begin
            bad_cnt   <= '0;
            clean_cnt <= '0;
        end else if (err_cyc) begin
            bad_cnt   <= bad_cnt + 1'b1;
            clean_cnt <= '0;
        end else begin
            if (clean_cnt == CLEAN_LAST) begin
                bad_cnt <= '0;
            end
            if (clean_cnt != CLEAN_FULL) begin
                clean_cnt <= clean_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rst_code_rx.sv
// Backend receiver for the serial reset-code line.
// Captures the line into a short history, detects active frames while the
// line is locked, and produces a reset strobe, a stretched reset and counters.
module rst_code_rx
    import rst_code_pkg::*;
#(
    parameter int LOCK_COUNT  = 16,
    parameter int UNLOCK_ERRS = 2,
    parameter int RST_HOLD    = 16
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        m_rst_in,
    output logic        locked,
    output logic        rst_pulse,
    output logic        rst_out,
    output logic [15:0] rst_count,
    output logic [7:0]  err_count
);

    localparam int                HOLD_W    = $clog2(RST_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD);

    logic [HIST_W-1:0] hist;
    logic [HOLD_W-1:0] hold_cnt;
    logic              det;
    logic              err_cyc;
    logic              fire;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Input capture and bit history; hist[0] is the newest bit
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
        end else begin
            hist <= {hist[HIST_W-2:0], m_rst_in};
        end
    end

    assign det     = (hist == DET_PATTERN);
    assign err_cyc = is_err_window(hist[2:0]);
    assign fire    = locked & det;

    rst_code_lock #(
        .LOCK_COUNT  (LOCK_COUNT),
        .UNLOCK_ERRS (UNLOCK_ERRS)
    ) u_lock (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .hist    (hist),
        .locked  (locked)
    );

    // One-cycle strobe and wrapping count of detected active frames
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pulse <= 1'b0;
            rst_count <= '0;
        end else begin
            rst_pulse <= fire;
            if (fire) begin
                rst_count <= rst_count + 16'd1;
            end
        end
    end

    // Saturating count of illegal-pattern cycles seen while locked
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (locked && err_cyc) begin
            err_count <= sat_inc8(err_count);
        end
    end

    // Reset stretcher; a new detection restarts the hold, loss of lock does not cut it
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (fire) begin
            hold_cnt <= HOLD_LOAD;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

    assign rst_out = (hold_cnt != '0);

endmodule

// File: tb/tb_rst_code_rx.sv
// Self-checking bench for rst_code_rx: directed scenarios plus randomized
// frame streams, every cycle compared against a behavioural line model.
module tb_rst_code_rx;

    localparam int LOCK_COUNT  = 16;
    localparam int UNLOCK_ERRS = 2;
    localparam int RST_HOLD    = 16;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        m_rst_in = 1'b0;
    logic        locked;
    logic        rst_pulse;
    logic        rst_out;
    logic [15:0] rst_count;
    logic [7:0]  err_count;

    rst_code_rx #(
        .LOCK_COUNT  (LOCK_COUNT),
        .UNLOCK_ERRS (UNLOCK_ERRS),
        .RST_HOLD    (RST_HOLD)
    ) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .m_rst_in  (m_rst_in),
        .locked    (locked),
        .rst_pulse (rst_pulse),
        .rst_out   (rst_out),
        .rst_count (rst_count),
        .err_count (err_count)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit hist_q[$];     // received bits, newest at the back
    bit m_locked;
    int m_run;         // consecutive transitions while hunting
    int m_bad;         // error cycles not yet forgiven
    int m_clean;       // clean cycles since last error
    bit m_pulse;
    int m_hold;
    int m_rcnt;
    int m_ecnt;

    function automatic void model_reset();
        hist_q.delete();
        for (int i = 0; i < 5; i++) hist_q.push_back(1'b0);
        m_locked = 0; m_run = 0; m_bad = 0; m_clean = 0;
        m_pulse = 0; m_hold = 0; m_rcnt = 0; m_ecnt = 0;
    endfunction

    // Advance the model by one clock edge at which bit b is captured.
    function automatic void model_edge(input bit b);
        int n = hist_q.size();
        bit det, err, trans;
        det   = (hist_q[n-5] == 0) && (hist_q[n-4] == 1) && (hist_q[n-3] == 1)
                && (hist_q[n-2] == 0) && (hist_q[n-1] == 0);
        err   = (hist_q[n-1] == hist_q[n-2]) && (hist_q[n-2] == hist_q[n-3]);
        trans = (hist_q[n-1] != hist_q[n-2]);
        m_pulse = m_locked && det;
        if (m_locked && det) begin
            m_hold = RST_HOLD;
            m_rcnt = (m_rcnt + 1) % 65536;
        end else if (m_hold > 0) begin
            m_hold = m_hold - 1;
        end
        if (m_locked) begin
            if (err) begin
                if (m_ecnt < 255) m_ecnt++;
                m_bad++;
                m_clean = 0;
                if (m_bad >= UNLOCK_ERRS) begin
                    m_locked = 0;
                    m_run = 0;
                end
            end else begin
                m_clean++;
                if (m_clean >= 8) m_bad = 0;
            end
        end else if (trans) begin
            m_run++;
            if (m_run == LOCK_COUNT) begin
                m_locked = 1; m_run = 0; m_bad = 0; m_clean = 0;
            end
        end else begin
            m_run = 0;
        end
        hist_q.push_back(b);
        if (hist_q.size() > 8) void'(hist_q.pop_front());
    endfunction

    // ---------------- stimulus helpers ----------------
    int step_no = 0;
    int pulse_steps[$];
    int hi_cycles;
    int first_hi;
    int last_hi;

    task automatic clear_obs();
        pulse_steps.delete();
        hi_cycles = 0; first_hi = -1; last_hi = -1;
    endtask

    // Present one bit, clock it in, then compare on the falling edge.
    task automatic step(input bit b);
        m_rst_in = b;
        @(posedge sys_clk);
        model_edge(b);
        step_no++;
        @(negedge sys_clk);
        chk("locked", locked, m_locked);
        chk("rst_pulse", rst_pulse, m_pulse);
        chk("rst_out", rst_out, (m_hold != 0));
        chk("rst_count", rst_count, m_rcnt);
        chk("err_count", err_count, m_ecnt);
        if (rst_pulse) pulse_steps.push_back(step_no);
        if (rst_out) begin
            hi_cycles++;
            if (first_hi < 0) first_hi = step_no;
            last_hi = step_no;
        end
    endtask

    task automatic send_frame(input logic [3:0] f);
        for (int i = 3; i >= 0; i--) step(f[i]);
    endtask

    task automatic idle_until_locked(input int max_frames);
        for (int i = 0; i < max_frames && !locked; i++) send_frame(4'b1010);
        chk("lock_acquired", locked, 1);
    endtask

    // Called at a falling edge; checks the cleared state while reset is held.
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_pulse0", rst_pulse, 0);
        chk("rst_out0", rst_out, 0);
        chk("rst_rcnt0", rst_count, 0);
        chk("rst_ecnt0", err_count, 0);
        @(negedge sys_clk);
        rst_n = 1'b1;
    endtask

    int lock_step;
    int drop_bit;
    int last_bit;
    int hi_seen;
    logic [3:0] f;

    initial begin
        model_reset();
        @(negedge sys_clk);
        do_reset();

        // Line lock from idle
        clear_obs();
        lock_step = -1;
        for (int i = 0; i < 40; i++) begin
            step((i % 2) == 0);
            if (locked && lock_step < 0) lock_step = i + 1;
        end
        chk("lock_within_17", (lock_step > 0) && (lock_step <= 17), 1);
        chk("lock_no_pulse", pulse_steps.size(), 0);
        chk("lock_ecnt", err_count, 0);

        // Single active frame
        clear_obs();
        send_frame(4'b1100);
        last_bit = step_no;
        for (int i = 0; i < 6; i++) send_frame(4'b1010);
        chk("single_pulses", pulse_steps.size(), 1);
        chk("single_latency", (pulse_steps.size() > 0) ? pulse_steps[0] - last_bit : -1, 1);
        chk("single_hold", hi_cycles, 16);
        chk("single_rcnt", rst_count, 1);

        // Back-to-back active frames
        do_reset();
        idle_until_locked(10);
        clear_obs();
        send_frame(4'b1100);
        send_frame(4'b1100);
        for (int i = 0; i < 8; i++) send_frame(4'b1010);
        chk("b2b_pulses", pulse_steps.size(), 2);
        chk("b2b_spacing", (pulse_steps.size() == 2) ? pulse_steps[1] - pulse_steps[0] : -1, 4);
        chk("b2b_hold", hi_cycles, 20);
        chk("b2b_contiguous", last_hi - first_hi + 1, 20);
        chk("b2b_rcnt", rst_count, 2);
        chk("b2b_ecnt", err_count, 0);

        // Stuck-high line, then recovery
        clear_obs();
        drop_bit = -1;
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            if (!locked && drop_bit < 0) drop_bit = i + 1;
        end
        chk("stuck_unlock_bit", drop_bit, 5);
        chk("stuck_ecnt", err_count, 2);
        chk("stuck_no_pulse", pulse_steps.size(), 0);
        idle_until_locked(8);

        // Active frame while hunting
        do_reset();
        clear_obs();
        send_frame(4'b1010);
        send_frame(4'b1010);
        send_frame(4'b1100);
        chk("hunt_not_locked", locked, 0);
        idle_until_locked(10);
        chk("hunt_no_pulse", pulse_steps.size(), 0);
        chk("hunt_rcnt", rst_count, 0);

        // Asynchronous reset in the middle of a hold
        send_frame(4'b1100);
        hi_seen = 0;
        for (int i = 0; i < 30 && hi_seen < 5; i++) begin
            step((i % 2) == 0);
            if (rst_out) hi_seen++;
        end
        chk("hold_reached", hi_seen, 5);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out", rst_out, 0);
        chk("async_locked", locked, 0);
        chk("async_rcnt", rst_count, 0);
        chk("async_ecnt", err_count, 0);
        model_reset();
        rst_n = 1'b1;

        // Randomized frame stream
        for (int k = 0; k < 300; k++) begin
            int r = $urandom_range(0, 9);
            if (r <= 5) begin
                send_frame(4'b1010);
            end else if (r <= 7) begin
                send_frame(4'b1100);
            end else if (r == 8) begin
                int p = $urandom_range(0, 3);
                f = 4'b1010;
                f[p] = ~f[p];
                send_frame(f);
            end else begin
                bit v = bit'($urandom_range(0, 1));
                int len = $urandom_range(3, 8);
                for (int j = 0; j < len; j++) step(v);
            end
        end

        // Error counter saturation with isolated errors that never unlock
        do_reset();
        idle_until_locked(10);
        for (int k = 0; k < 270; k++) begin
            send_frame(4'b1110);
            send_frame(4'b1010);
            send_frame(4'b1010);
            send_frame(4'b1010);
        end
        chk("sat_ecnt", err_count, 255);
        chk("sat_locked", locked, 1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
